// File: rtl/sysid_regfile.sv
// System-ID peripheral on an Avalon-MM slave: build ID, timestamp, atomic uptime, scratch, control/status.
// Optional heartbeat interrupt is built only when SYSID_HEARTBEAT_EN is defined.
module sysid_regfile #(
    parameter logic [31:0] ID_VALUE    = 32'h51A45AF5,
    parameter logic [31:0] TIMESTAMP   = 32'h0,
    parameter int          UPTIME_W    = 64,
    parameter logic [31:0] SCRATCH_RST = 32'h0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    output logic        irq
);

    localparam logic [UPTIME_W-1:0] UPTIME_ONE = {{(UPTIME_W-1){1'b0}}, 1'b1};

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

    logic [UPTIME_W-1:0] r_uptime;
    logic [31:0]         r_hi_shadow;
    logic [31:0]         r_scratch;
    logic                r_count_en;
    logic                r_wrap;
    logic [31:0]         r_rdata;
    logic                r_rvalid;
    logic                r_irq;

    logic                w_wr_en;
    logic                w_rd_en;
    logic                w_ctrl_en0;
    logic                w_clear;
    logic [1:0]          w_st_w1c;
    logic [63:0]         w_uptime_ext;
    logic [UPTIME_W-1:0] w_uptime_nxt;
    logic                w_wrap_set;
    logic                w_wrap_nxt;
    logic                w_count_en_nxt;
    logic [31:0]         w_rdata;
    logic [31:0]         w_ctrl_rd;
    logic [31:0]         w_hb_rd;
    logic                w_pend_rd;
    logic                w_irq_nxt;

`ifdef SYSID_HEARTBEAT_EN
    logic        r_irq_en;
    logic        r_hb_pending;
    logic [31:0] r_hb_period;
    logic [31:0] r_hb_cnt;
    logic        w_wr_hb;
    logic [31:0] w_hb_wdata;
    logic [31:0] w_hb_cnt_nxt;
    logic        w_hb_tick;
    logic        w_pend_nxt;
    logic        w_irq_en_nxt;

    // Heartbeat down-counter, pending flag and irq source
    always_comb begin
        w_wr_hb      = w_wr_en && (address == 3'd7);
        w_hb_wdata   = be_merge(r_hb_period, writedata, byteenable);
        w_hb_tick    = 1'b0;
        w_hb_cnt_nxt = r_hb_cnt;
        if (w_wr_hb) begin
            w_hb_cnt_nxt = (w_hb_wdata == 32'd0) ? 32'd0 : (w_hb_wdata - 32'd1);
        end else if (r_hb_period == 32'd0) begin
            w_hb_cnt_nxt = 32'd0;
        end else if (r_hb_cnt == 32'd0) begin
            w_hb_tick    = 1'b1;
            w_hb_cnt_nxt = r_hb_period - 32'd1;
        end else begin
            w_hb_cnt_nxt = r_hb_cnt - 32'd1;
        end
        // A tick in the same edge as the W1C keeps the bit set
        w_pend_nxt   = w_hb_tick | (r_hb_pending & ~w_st_w1c[0]);
        w_irq_en_nxt = w_ctrl_en0 ? writedata[2] : r_irq_en;
        w_irq_nxt    = w_pend_nxt & w_irq_en_nxt;
        w_ctrl_rd    = {29'd0, r_irq_en, 1'b0, r_count_en};
        w_hb_rd      = r_hb_period;
        w_pend_rd    = r_hb_pending;
    end

    // Heartbeat state registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_en     <= 1'b0;
            r_hb_pending <= 1'b0;
            r_hb_period  <= 32'd0;
            r_hb_cnt     <= 32'd0;
        end else begin
            r_irq_en     <= w_irq_en_nxt;
            r_hb_pending <= w_pend_nxt;
            r_hb_cnt     <= w_hb_cnt_nxt;
            if (w_wr_hb) begin
                r_hb_period <= w_hb_wdata;
            end
        end
    end
`else
    // Without the heartbeat, word 7, STATUS.b0 and CTRL.b2 read as zero
    always_comb begin
        w_irq_nxt = 1'b0;
        w_ctrl_rd = {31'd0, r_count_en};
        w_hb_rd   = 32'd0;
        w_pend_rd = 1'b0;
    end
`endif

    // Bus decode, uptime next state and STATUS.wrap
    always_comb begin
        w_wr_en        = chipselect & write;
        w_rd_en        = chipselect & read & ~write;
        w_ctrl_en0     = w_wr_en && (address == 3'd5) && byteenable[0];
        w_clear        = w_ctrl_en0 & writedata[1];
        w_count_en_nxt = w_ctrl_en0 ? writedata[0] : r_count_en;
        w_st_w1c       = (w_wr_en && (address == 3'd6) && byteenable[0]) ? writedata[1:0] : 2'b00;
        w_uptime_ext   = 64'(r_uptime);
        w_wrap_set     = 1'b0;
        if (w_clear) begin
            w_uptime_nxt = '0;
        end else if (r_count_en) begin
            w_uptime_nxt = r_uptime + UPTIME_ONE;
            w_wrap_set   = &r_uptime;
        end else begin
            w_uptime_nxt = r_uptime;
        end
        w_wrap_nxt = w_wrap_set | (r_wrap & ~w_st_w1c[1]);
    end

    // Read data mux over the current register values
    always_comb begin
        case (address)
            3'd0:    w_rdata = ID_VALUE;
            3'd1:    w_rdata = TIMESTAMP;
            3'd2:    w_rdata = w_uptime_ext[31:0];
            3'd3:    w_rdata = r_hi_shadow;
            3'd4:    w_rdata = r_scratch;
            3'd5:    w_rdata = w_ctrl_rd;
            3'd6:    w_rdata = {30'd0, r_wrap, w_pend_rd};
            3'd7:    w_rdata = w_hb_rd;
            default: w_rdata = 32'd0;
        endcase
    end

    // Core registers and registered bus outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_uptime    <= '0;
            r_hi_shadow <= 32'd0;
            r_scratch   <= SCRATCH_RST;
            r_count_en  <= 1'b1;
            r_wrap      <= 1'b0;
            r_rdata     <= 32'd0;
            r_rvalid    <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            r_uptime   <= w_uptime_nxt;
            r_count_en <= w_count_en_nxt;
            r_wrap     <= w_wrap_nxt;
            r_rvalid   <= w_rd_en;
            r_irq      <= w_irq_nxt;
            if (w_wr_en && (address == 3'd4)) begin
                r_scratch <= be_merge(r_scratch, writedata, byteenable);
            end
            if (w_rd_en) begin
                r_rdata <= w_rdata;
            end
            // Reading UPTIME_LO snapshots the upper half so word 3 pairs with it
            if (w_rd_en && (address == 3'd2)) begin
                r_hi_shadow <= w_uptime_ext[63:32];
            end
        end
    end

    assign readdata      = r_rdata;
    assign readdatavalid = r_rvalid;
    assign irq           = r_irq;

endmodule

// File: tb/tb_sysid_regfile.sv
// Directed self-checking bench for sysid_regfile (40-bit uptime instance).
// Heartbeat checks follow SYSID_HEARTBEAT_EN like the design.
module tb_sysid_regfile;

    localparam logic [31:0] TS = 32'h6650_1234;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    sysid_regfile #(
        .ID_VALUE    (32'h51A45AF5),
        .TIMESTAMP   (TS),
        .UPTIME_W    (40),
        .SCRATCH_RST (32'h0)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .address       (address),
        .chipselect    (chipselect),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .irq           (irq)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; the access lands on the next rising edge.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        address = a; writedata = d; byteenable = be; chipselect = 1'b1; write = 1'b1;
        @(negedge clock);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        address = a; chipselect = 1'b1; read = 1'b1;
        @(negedge clock);
        chipselect = 1'b0; read = 1'b0;
        check_eq(tag, readdata, exp);
        check_eq({tag, "_valid"}, {31'd0, readdatavalid}, 32'd1);
    endtask

    initial begin
        reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        writedata = 32'd0; byteenable = 4'd0;
        repeat (2) @(negedge clock);
        check_eq("rst_readdata", readdata, 32'd0);
        check_eq("rst_valid", {31'd0, readdatavalid}, 32'd0);
        check_eq("rst_irq", {31'd0, irq}, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // ID / timestamp with latency 1, valid for one cycle only
        read_chk("id", 3'd0, 32'h51A45AF5);
        read_chk("timestamp", 3'd1, TS);
        @(negedge clock);
        check_eq("valid_drop", {31'd0, readdatavalid}, 32'd0);
        check_eq("rdata_hold", readdata, TS);
        read_chk("rst_scratch", 3'd4, 32'h0);
        read_chk("rst_ctrl", 3'd5, 32'h1);
        read_chk("rst_status", 3'd6, 32'h0);
        read_chk("rst_hb", 3'd7, 32'h0);

        // Byte lanes, RO write, chipselect low, read+write collision
        bus_write(3'd4, 32'hDEADBEEF, 4'b0101);
        read_chk("scratch_be", 3'd4, 32'h00AD00EF);
        bus_write(3'd0, 32'h12345678, 4'hF);
        read_chk("id_ro", 3'd0, 32'h51A45AF5);
        address = 3'd4; writedata = 32'hFFFF_FFFF; byteenable = 4'hF; write = 1'b1;
        @(negedge clock);
        write = 1'b0;
        read_chk("cs_low", 3'd4, 32'h00AD00EF);
        address = 3'd4; writedata = 32'h1357_9BDF; byteenable = 4'hF;
        chipselect = 1'b1; read = 1'b1; write = 1'b1;
        @(negedge clock);
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        check_eq("rw_same_valid", {31'd0, readdatavalid}, 32'd0);
        read_chk("rw_same_data", 3'd4, 32'h1357_9BDF);

        // Atomic uptime and wrap of a 40-bit counter
        address = 3'd2; chipselect = 1'b1; read = 1'b1;
        force dut.r_uptime = 40'hFF_FFFF_FFFE;
        #1;
        release dut.r_uptime;
        @(negedge clock);
        chipselect = 1'b0; read = 1'b0;
        check_eq("uptime_lo", readdata, 32'hFFFF_FFFE);
        read_chk("uptime_hi", 3'd3, 32'h0000_00FF);
        read_chk("wrap_set", 3'd6, 32'h2);
        bus_write(3'd6, 32'h2, 4'b0000);
        read_chk("w1c_no_lane", 3'd6, 32'h2);
        bus_write(3'd6, 32'h2, 4'b0001);
        read_chk("w1c_wrap", 3'd6, 32'h0);

        // Clear beats increment, then freeze at a known count
        bus_write(3'd5, 32'h3, 4'h1);
        repeat (5) @(negedge clock);
        bus_write(3'd5, 32'h0, 4'h1);
        read_chk("uptime_after_clr", 3'd2, 32'd6);
        read_chk("uptime_hi_zero", 3'd3, 32'd0);
        repeat (100) @(negedge clock);
        read_chk("uptime_frozen", 3'd2, 32'd6);
        read_chk("ctrl_zero", 3'd5, 32'h0);

`ifdef SYSID_HEARTBEAT_EN
        bus_write(3'd5, 32'h5, 4'h1);
        bus_write(3'd7, 32'd10, 4'hF);
        repeat (9) @(negedge clock);
        check_eq("hb_irq_early", {31'd0, irq}, 32'd0);
        @(negedge clock);
        check_eq("hb_irq_rise", {31'd0, irq}, 32'd1);
        read_chk("hb_status", 3'd6, 32'h1);
        bus_write(3'd6, 32'h1, 4'h1);
        check_eq("hb_irq_clr", {31'd0, irq}, 32'd0);
        repeat (7) @(negedge clock);
        check_eq("hb_irq_early2", {31'd0, irq}, 32'd0);
        @(negedge clock);
        check_eq("hb_irq_rise2", {31'd0, irq}, 32'd1);
        repeat (9) @(negedge clock);
        bus_write(3'd6, 32'h1, 4'h1);
        check_eq("hb_set_wins", {31'd0, irq}, 32'd1);
        read_chk("hb_period", 3'd7, 32'd10);
        read_chk("hb_ctrl", 3'd5, 32'h5);
`else
        bus_write(3'd5, 32'h5, 4'h1);
        bus_write(3'd7, 32'd10, 4'hF);
        repeat (15) @(negedge clock);
        check_eq("nohb_irq", {31'd0, irq}, 32'd0);
        read_chk("nohb_period", 3'd7, 32'd0);
        read_chk("nohb_ctrl", 3'd5, 32'h1);
        read_chk("nohb_status", 3'd6, 32'h0);
`endif

        // Reset right after a read drops the pending valid
        read_chk("pre_rst_id", 3'd0, 32'h51A45AF5);
        reset_n = 1'b0;
        #1;
        check_eq("midrst_valid", {31'd0, readdatavalid}, 32'd0);
        check_eq("midrst_irq", {31'd0, irq}, 32'd0);
        check_eq("midrst_rdata", readdata, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        read_chk("post_rst_ctrl", 3'd5, 32'h1);
        read_chk("post_rst_status", 3'd6, 32'h0);
        read_chk("post_rst_scratch", 3'd4, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
